// File: rtl/c4b_pkg.sv
// Shared constants for the c4b up-counter and the benches that exercise it.
package c4b_pkg;

    localparam int         C4B_WIDTH = 4;
    localparam logic [3:0] C4B_MAX   = 4'hF;

endpackage

// File: rtl/c4b_tff.sv
// T flip-flop with asynchronous active-low clear; toggles on rising clk when t is high.
module c4b_tff (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg <= 1'b0;
        end else if (t) begin
            q_reg <= ~q_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/c4b.sv
// Synchronous binary up-counter with count enable, built from a chain of T flip-flops.
module c4b
    import c4b_pkg::*;
#(
    parameter int WIDTH = C4B_WIDTH
) (
    output logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             reset,
    input  logic             clk
);

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q_reg;

    // Bit i toggles only when every lower bit is 1, so all bits flip on the same edge.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign t[gi] = en;
            end else begin : g_upper
                assign t[gi] = en & (&q_reg[gi-1:0]);
            end

            c4b_tff u_tff (
                .clk   (clk),
                .reset (reset),
                .t     (t[gi]),
                .q     (q_reg[gi])
            );
        end
    endgenerate

    assign q = q_reg;

endmodule

// File: tb/tb_c4b.sv
// Directed and randomized checks of c4b against an integer modulo-count model.
module tb_c4b;
    import c4b_pkg::*;

    localparam int W   = C4B_WIDTH;
    localparam int MOD = int'(C4B_MAX) + 1;

    logic         clk;
    logic         reset;
    logic         en;
    logic [W-1:0] q;

    int tests  = 0;
    int failed = 0;
    int model  = 0;

    c4b #(.WIDTH(W)) dut (
        .q     (q),
        .en    (en),
        .reset (reset),
        .clk   (clk)
    );

    // Rising edges at 10, 20, 30, ...
    initial begin
        clk = 1'b0;
        #10;
        forever begin
            clk = 1'b1;
            #5;
            clk = 1'b0;
            #5;
        end
    end

    task automatic check(input string tag, input logic [W-1:0] exp);
        tests++;
        assert (q === exp)
        else begin
            failed++;
            $error("FAIL %s: q=%0d expected %0d at t=%0t", tag, q, exp, $time);
        end
    endtask

    // Drive en, take one rising edge, advance the model, then compare on the falling edge.
    task automatic step(input logic en_v, input string tag);
        logic [W-1:0] exp;
        en = en_v;
        @(posedge clk);
        if (reset === 1'b1 && en_v === 1'b1) begin
            model = (model + 1) % MOD;
        end
        @(negedge clk);
        exp = model[W-1:0];
        $display("[TB] %s en=%0b reset=%0b q=%0d exp=%0d", tag, en_v, reset, q, exp);
        check(tag, exp);
    endtask

    initial begin
        // Reset held low from time 0, en low.
        reset = 1'b0;
        en    = 1'b0;
        model = 0;
        #1;
        check("rst_async", '0);
        @(negedge clk);
        check("rst_hold_edge", '0);
        step(1'b1, "rst_ignores_en");

        // Release with en low: q stays 0.
        reset = 1'b1;
        step(1'b0, "rel_en0");
        step(1'b0, "rel_en0");

        // Counting 1..5.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, "count");
        end
        check("count5", 4'd5);

        // Clear, then 20 enabled edges: passes 15, wraps to 0, ends at 4.
        reset = 1'b0;
        model = 0;
        #1;
        check("clr_before_wrap", '0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, "wrap");
        end
        check("wrap20", 4'd4);

        // Reach 9, hold with en low, resume.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, "to9");
        end
        check("at9", 4'd9);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, "hold");
        end
        step(1'b1, "resume");
        check("ten", 4'd10);

        // From 10, 13 increments lands on 7; then clear between edges.
        for (int i = 0; i < 13; i++) begin
            step(1'b1, "to7");
        end
        check("at7", 4'd7);
        #2;
        reset = 1'b0;
        model = 0;
        #1;
        check("mid_clr", '0);
        #1;
        reset = 1'b1;
        step(1'b1, "restart");
        check("one", 4'd1);

        // Reset asserted coincident with a rising edge while en is high.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, "pre_coinc");
        end
        @(posedge clk);
        reset = 1'b0;
        en    = 1'b1;
        model = 0;
        #1;
        check("coinc", '0);
        @(negedge clk);
        check("coinc_hold", '0);
        reset = 1'b1;
        step(1'b1, "after_coinc");

        // Random enables with occasional mid-cycle reset pulses.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                #1;
                reset = 1'b0;
                model = 0;
                #1;
                check("rnd_clr", '0);
                if ($urandom_range(0, 1) == 1) begin
                    reset = 1'b1;
                end
            end
            step(1'($urandom_range(0, 1)), "rnd");
            reset = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
